// File: rtl/sw_clock_core.sv
// Stopwatch and time-of-day clock driven by a shared 10 ms tick divider.
// Both counters share the carry chain; the clock accepts per-field adjust buttons.
module sw_clock_core #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_mode,
    input  logic       btn_run,
    input  logic       btn_clear,
    input  logic       btn_sec,
    input  logic       btn_min,
    input  logic       btn_hour,
    output logic [6:0] sw_csec,
    output logic [5:0] sw_sec,
    output logic [5:0] sw_min,
    output logic [4:0] sw_hour,
    output logic [6:0] ck_csec,
    output logic [5:0] ck_sec,
    output logic [5:0] ck_min,
    output logic [4:0] ck_hour,
    output logic       sw_running
);
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {STOP, RUN, CLEAR} sw_state_t;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] csec;
    } hms_t;

    function automatic hms_t advance(input hms_t t);
        hms_t n;
        n = t;
        if (t.csec == 7'd99) begin
            n.csec = '0;
            if (t.sec == 6'd59) begin
                n.sec = '0;
                if (t.min == 6'd59) begin
                    n.min  = '0;
                    n.hour = (t.hour == 5'd23) ? '0 : t.hour + 5'd1;
                end else begin
                    n.min = t.min + 6'd1;
                end
            end else begin
                n.sec = t.sec + 6'd1;
            end
        end else begin
            n.csec = t.csec + 7'd1;
        end
        return n;
    endfunction

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             armed;
    logic [4:0]       btn_now;
    logic [4:0]       btn_hist;
    logic [4:0]       rise;
    logic             ev_run, ev_clear, ev_sec, ev_min, ev_hour;
    sw_state_t        state;
    hms_t             sw_t;
    hms_t             ck_t;

    assign tick    = (div == DIV_LAST);
    assign btn_now = {btn_hour, btn_min, btn_sec, btn_clear, btn_run};
    // History is cleared by reset, so the first cycle after release only
    // captures levels; a button held through reset cannot fire an event.
    assign rise    = armed ? (btn_now & ~btn_hist) : '0;

    assign ev_run   = rise[0] & ~sw_mode;
    assign ev_clear = rise[1] & ~sw_mode;
    assign ev_sec   = rise[2] &  sw_mode;
    assign ev_min   = rise[3] &  sw_mode;
    assign ev_hour  = rise[4] &  sw_mode;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div        <= '0;
            armed      <= 1'b0;
            btn_hist   <= '0;
            state      <= STOP;
            sw_running <= 1'b0;
            sw_t       <= '0;
            ck_t       <= '0;
        end else begin
            div      <= tick ? '0 : div + 1'b1;
            armed    <= 1'b1;
            btn_hist <= btn_now;

            case (state)
                STOP: begin
                    if (ev_run) begin
                        state      <= RUN;
                        sw_running <= 1'b1;
                    end else if (ev_clear) begin
                        state <= CLEAR;
                    end
                end
                RUN: begin
                    if (ev_run) begin
                        state      <= STOP;
                        sw_running <= 1'b0;
                    end
                end
                default: begin
                    state      <= STOP;
                    sw_running <= 1'b0;
                end
            endcase

            if (state == CLEAR)
                sw_t <= '0;
            else if (state == RUN && tick)
                sw_t <= advance(sw_t);

            // An adjust takes the cycle; a coincident tick is lost for the clock.
            if (ev_hour)
                ck_t.hour <= (ck_t.hour == 5'd23) ? '0 : ck_t.hour + 5'd1;
            else if (ev_min)
                ck_t.min <= (ck_t.min == 6'd59) ? '0 : ck_t.min + 6'd1;
            else if (ev_sec)
                ck_t.sec <= (ck_t.sec == 6'd59) ? '0 : ck_t.sec + 6'd1;
            else if (tick)
                ck_t <= advance(ck_t);
        end
    end

    assign sw_csec = sw_t.csec;
    assign sw_sec  = sw_t.sec;
    assign sw_min  = sw_t.min;
    assign sw_hour = sw_t.hour;
    assign ck_csec = ck_t.csec;
    assign ck_sec  = ck_t.sec;
    assign ck_min  = ck_t.min;
    assign ck_hour = ck_t.hour;
endmodule

// File: tb/tb_sw_clock_core.sv
// Directed bench for sw_clock_core with TICK_DIV=4: ticks land on every 4th
// edge after reset release, so expected counts are derived from edge numbers.
module tb_sw_clock_core;
    logic       clk = 1'b0;
    logic       rst, sw_mode, btn_run, btn_clear, btn_sec, btn_min, btn_hour;
    logic [6:0] sw_csec, ck_csec;
    logic [5:0] sw_sec, sw_min, ck_sec, ck_min;
    logic [4:0] sw_hour, ck_hour;
    logic       sw_running;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    sw_clock_core #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_mode    (sw_mode),
        .btn_run    (btn_run),
        .btn_clear  (btn_clear),
        .btn_sec    (btn_sec),
        .btn_min    (btn_min),
        .btn_hour   (btn_hour),
        .sw_csec    (sw_csec),
        .sw_sec     (sw_sec),
        .sw_min     (sw_min),
        .sw_hour    (sw_hour),
        .ck_csec    (ck_csec),
        .ck_sec     (ck_sec),
        .ck_min     (ck_min),
        .ck_hour    (ck_hour),
        .sw_running (sw_running)
    );

    always #5 clk = ~clk;

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int unsigned which, input logic v);
        case (which)
            0: btn_sec  = v;
            1: btn_min  = v;
            default: btn_hour = v;
        endcase
    endtask

    task automatic pulse(input int unsigned which);
        set_btn(which, 1'b1);
        step(1);
        set_btn(which, 1'b0);
        step(1);
    endtask

    initial begin
        rst = 1'b0; sw_mode = 1'b0;
        btn_run = 1'b0; btn_clear = 1'b0; btn_sec = 1'b0; btn_min = 1'b0; btn_hour = 1'b0;
        step(2);
        check("rst_sw_csec", 32'(sw_csec), 0);
        check("rst_ck_csec", 32'(ck_csec), 0);
        check("rst_running", 32'(sw_running), 0);

        // Edge numbers below count from reset release (E1 = first edge).
        rst = 1'b1;
        step(1);                              // E1
        btn_run = 1'b1; step(1);              // E2: STOP->RUN
        btn_run = 1'b0;
        check("run_start", 32'(sw_running), 1);
        check("run_start_csec", 32'(sw_csec), 0);
        step(400);                            // E402: 100 ticks
        check("run400_sec", 32'(sw_sec), 1);
        check("run400_csec", 32'(sw_csec), 0);
        check("run400_running", 32'(sw_running), 1);
        check("ck400_sec", 32'(ck_sec), 1);
        btn_run = 1'b1; step(1);              // E403: RUN->STOP
        btn_run = 1'b0;
        check("stop_running", 32'(sw_running), 0);
        step(20);                             // E423
        check("frozen_sec", 32'(sw_sec), 1);
        check("frozen_csec", 32'(sw_csec), 0);
        check("ck423_csec", 32'(ck_csec), 5);

        btn_run = 1'b1; step(1);              // E424: STOP->RUN
        btn_run = 1'b0;
        step(3);                              // E427
        btn_clear = 1'b1; step(1);            // E428: clear ignored, tick counts
        btn_clear = 1'b0;
        step(1);                              // E429
        check("clr_in_run_running", 32'(sw_running), 1);
        check("clr_in_run_csec", 32'(sw_csec), 1);
        check("clr_in_run_sec", 32'(sw_sec), 1);
        btn_run = 1'b1; step(1);              // E430: RUN->STOP
        btn_run = 1'b0;
        step(1);                              // E431
        btn_clear = 1'b1; step(1);            // E432: STOP->CLEAR
        btn_clear = 1'b0;
        check("clear_pending_csec", 32'(sw_csec), 1);
        step(1);                              // E433: counters zeroed
        check("cleared_csec", 32'(sw_csec), 0);
        check("cleared_sec", 32'(sw_sec), 0);
        check("cleared_min", 32'(sw_min), 0);
        check("cleared_hour", 32'(sw_hour), 0);
        check("cleared_running", 32'(sw_running), 0);
        check("ck433_csec", 32'(ck_csec), 8);

        sw_mode = 1'b1;
        btn_run = 1'b1; step(1);              // E434: gated in clock mode
        check("gated_run", 32'(sw_running), 0);
        step(2);                              // E436
        sw_mode = 1'b0; step(3);              // E439: held level, no event
        check("mode_switch_no_event", 32'(sw_running), 0);
        btn_run = 1'b0;
        btn_min = 1'b1; step(1);              // E440: gated in stopwatch mode
        check("gated_min", 32'(ck_min), 0);
        btn_min = 1'b0; step(1);              // E441

        sw_mode = 1'b1;
        btn_min = 1'b1; step(20);             // E442..E461, one event at E442
        check("held_min_once", 32'(ck_min), 1);
        btn_min = 1'b0; step(1);              // E462
        step(1);                              // E463
        btn_sec = 1'b1; step(1);              // E464: adjust wins over tick
        btn_sec = 1'b0;
        check("adj_tick_sec", 32'(ck_sec), 2);
        check("adj_tick_csec", 32'(ck_csec), 15);

        for (int i = 0; i < 58; i++) pulse(1); // events on odd edges E465..E579
        check("min59", 32'(ck_min), 59);
        check("min59_csec", 32'(ck_csec), 44);
        pulse(1);                             // E581 event, ends E582
        check("min_wrap", 32'(ck_min), 0);
        check("min_wrap_hour", 32'(ck_hour), 0);

        btn_sec = 1'b1; btn_min = 1'b1; btn_hour = 1'b1; step(1);   // E583
        btn_sec = 1'b0; btn_min = 1'b0; btn_hour = 1'b0; step(1);   // E584
        check("prio_hour", 32'(ck_hour), 1);
        check("prio_min", 32'(ck_min), 0);
        check("prio_sec", 32'(ck_sec), 2);

        sw_mode = 1'b0;
        btn_run = 1'b1; step(1);              // E585: STOP->RUN
        btn_run = 1'b0;
        step(20);                             // E605: RUN ticks at E588..E604
        check("rerun_csec", 32'(sw_csec), 5);
        check("rerun_running", 32'(sw_running), 1);

        rst = 1'b0; sw_mode = 1'b1; btn_hour = 1'b1;
        step(1);
        check("midrun_rst_sw_csec", 32'(sw_csec), 0);
        check("midrun_rst_ck_hour", 32'(ck_hour), 0);
        check("midrun_rst_ck_sec", 32'(ck_sec), 0);
        check("midrun_rst_running", 32'(sw_running), 0);
        step(1);

        // Edge numbers restart at the second reset release.
        rst = 1'b1;
        step(2);                              // E2, btn_hour held since reset
        check("held_through_rst", 32'(ck_hour), 0);
        btn_hour = 1'b0; step(2);             // E4
        for (int i = 0; i < 23; i++) pulse(2);
        for (int i = 0; i < 59; i++) pulse(1);
        for (int i = 0; i < 59; i++) pulse(0); // ends E286, 71 ticks so far
        step(110);                            // E396: 99 ticks
        check("pre_wrap_hour", 32'(ck_hour), 23);
        check("pre_wrap_min", 32'(ck_min), 59);
        check("pre_wrap_sec", 32'(ck_sec), 59);
        check("pre_wrap_csec", 32'(ck_csec), 99);
        step(4);                              // E400: final tick
        check("wrap_hour", 32'(ck_hour), 0);
        check("wrap_min", 32'(ck_min), 0);
        check("wrap_sec", 32'(ck_sec), 0);
        check("wrap_csec", 32'(ck_csec), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
